dmem_ctrl: RTL

- Parametrised successor to the single-cycle data memory, for the multicycle and pipelined cores.
- Adds a req/ready handshake with configurable wait states.
- Supports RISC-V byte, halfword and word loads/stores with sign/zero extension, plus misalignment detection.
- Sits between the core's load/store unit and on-chip RAM; the core stalls until ready.

---
 rtl/dmem_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Data memory controller with a req/ready handshake, WAIT_STATES wait cycles and RV32 sized loads/stores.
// The optional MMIO output register is compiled in when DMEM_MMIO_EN is defined.

module dmem_ctrl #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 64,
    parameter int              WAIT_STATES = 1,
    parameter logic [XLEN-1:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            ready,
    output logic            err,
    output logic [XLEN-1:0] mmio_out,
    output logic            mmio_valid
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = XLEN / 8;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] mmio_q, mmio_d;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [1:0]      lane;
    logic [AW-1:0]   widx;
    logic [XLEN-1:0] mem_word, src_word, load_val, wr_data, merged;
    logic [NB-1:0]   be;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic            illegal, misalign, mmio_hit, acc_err, resp, commit;

    // Handshake: the request is captured only in IDLE; ready is a single-cycle pulse
    // in RESP, and req is not re-sampled until the FSM is back in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lane     = addr_q[1:0];
        widx     = addr_q[AW+1:2];
        mem_word = mem[widx];
        resp     = (state_q == RESP);
        mmio_hit = MMIO_EN && (addr_q[XLEN-1:2] == MMIO_ADDR[XLEN-1:2]);

        if (we_q) illegal = (f3_q > 3'b010);
        else      illegal = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
        misalign = ((f3_q[1:0] == 2'b01) && lane[0]) ||
                   ((f3_q[1:0] == 2'b10) && (lane != 2'b00));
        acc_err  = illegal || misalign || (mmio_hit && (f3_q != 3'b010));

        src_word = mmio_hit ? mmio_q : mem_word;
        byte_sel = src_word[8*lane +: 8];
        half_sel = src_word[16*lane[1] +: 16];
        case (f3_q)
            3'b000:  load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b010:  load_val = src_word;
            3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, half_sel};
            default: load_val = '0;
        endcase

        // Store data is replicated across lanes so the byte enables alone pick the target bytes.
        case (f3_q[1:0])
            2'b00: begin
                wr_data = {NB{wdata_q[7:0]}};
                be      = NB'(1) << lane;
            end
            2'b01: begin
                wr_data = {(NB/2){wdata_q[15:0]}};
                be      = NB'(3) << {lane[1], 1'b0};
            end
            default: begin
                wr_data = wdata_q;
                be      = '1;
            end
        endcase
        merged = mem_word;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
        end

        commit = resp && we_q && !acc_err && reset;
        mmio_d = (commit && mmio_hit) ? wdata_q : mmio_q;
    end

    assign ready      = resp;
    assign err        = resp && acc_err;
    assign rdata      = (resp && !we_q && !acc_err) ? load_val : '0;
    assign mmio_valid = resp && we_q && !acc_err && mmio_hit;
    assign mmio_out   = mmio_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            mmio_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mmio_q  <= mmio_d;
        end
    end

    // RAM contents survive reset; an aborted store never reaches here because commit needs reset high.
    always_ff @(posedge clk) begin
        if (commit && !mmio_hit) mem[widx] <= merged;
    end

endmodule
